// File: rtl/td4_pkg.sv
// Shared types and constants for the td4 writable program store.
package td4_pkg;

    localparam int TD4_ADR_W  = 4;
    localparam int TD4_DATA_W = 8;
    localparam int TD4_DEPTH  = 2 ** TD4_ADR_W;

    // Boot sequencer states; the core runs only in RUN.
    typedef enum logic [2:0] {
        HOLD,
        LOAD,
        CHECK,
        RELEASE,
        RUN,
        ERROR
    } td4_ld_state_t;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Host-side byte stream and status flags of the program loader.
interface td4_prog_loader_if
    import td4_pkg::*;
#(
    parameter int DATA_W = TD4_DATA_W
);

    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              ld_err;

    modport master (
        output ld_start, ld_valid, ld_data,
        input  ld_ready, ld_done, ld_err
    );

    modport slave (
        input  ld_start, ld_valid, ld_data,
        output ld_ready, ld_done, ld_err
    );

endinterface

// File: rtl/td4_prog_ram.sv
// Program register file: one synchronous write port, one asynchronous read
// port feeding the core's instruction fetch.
module td4_prog_ram
    import td4_pkg::*;
#(
    parameter int ADR_W  = TD4_ADR_W,
    parameter int DATA_W = TD4_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADR_W-1:0]  wadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADR_W-1:0]  radr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear every entry on reset, otherwise store the accepted byte.
    // NOTE: the array is cleared through reset on purpose so a freshly reset
    // core never fetches stale code; that rules out a RAM macro, which is fine
    // at this depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wadr] <= wdata;
        end
    end

    // Asynchronous read keeps the timing of the ROM this store replaces.
    assign rdata = mem[radr];

endmodule

// File: rtl/td4_prog_loader.sv
// Boot sequencer for the td4 core: holds the core in reset while the host
// streams a program plus a checksum byte, and releases it only after a
// checksum-clean load.
module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int ADR_W  = TD4_ADR_W,
    parameter int DATA_W = TD4_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    td4_prog_loader_if.slave     ld,
    input  logic [ADR_W-1:0]     cpu_adr,
    output logic [DATA_W-1:0]    cpu_data,
    output logic                 cpu_reset
);

    td4_ld_state_t     state_q, state_d;
    logic [ADR_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] sum_next;
    logic              ready;
    logic              beat;
    logic              we;

    // Flags are pure decodes of the registered state, so they are glitch-free.
    assign ready        = (state_q == LOAD) || (state_q == CHECK);
    assign ld.ld_ready  = ready;
    assign ld.ld_done   = (state_q == RUN);
    assign ld.ld_err    = (state_q == ERROR);
    assign cpu_reset    = (state_q != RUN);

    assign beat     = ld.ld_valid & ready;
    assign sum_next = sum_q + ld.ld_data;

    // State, byte counter and running checksum registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state logic; a start request outranks any same-cycle beat.
    // NOTE: every variable gets its default before the case so no path leaves
    // one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        we      = 1'b0;
        unique case (state_q)
            HOLD, RUN, ERROR, LOAD, CHECK: begin
                if (ld.ld_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    sum_d   = '0;
                end else if (beat && state_q == LOAD) begin
                    we    = 1'b1;
                    sum_d = sum_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = CHECK;
                    end
                end else if (beat && state_q == CHECK) begin
                    // Checksum byte is consumed but never stored.
                    state_d = (sum_next == '0) ? RELEASE : ERROR;
                end
            end
            RELEASE: state_d = RUN;
            default: state_d = HOLD;
        endcase
    end

    td4_prog_ram #(
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .wadr  (cnt_q),
        .wdata (ld.ld_data),
        .radr  (cpu_adr),
        .rdata (cpu_data)
    );

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for the td4 program loader.
module tb_td4_prog_loader;
    import td4_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cpu_adr;
    logic [7:0] cpu_data;
    logic       cpu_reset;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] prog [TD4_DEPTH];

    td4_prog_loader_if #(.DATA_W(8)) ld_if ();

    td4_prog_loader #(.ADR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld        (ld_if),
        .cpu_adr   (cpu_adr),
        .cpu_data  (cpu_data),
        .cpu_reset (cpu_reset)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string name, input logic rst_w, input logic rdy_w,
                               input logic done_w, input logic err_w);
        n_cmp++;
        if ({cpu_reset, ld_if.ld_ready, ld_if.ld_done, ld_if.ld_err} !== {rst_w, rdy_w, done_w, err_w}) begin
            n_bad++;
            $display("FAIL %s: cpu_reset/ready/done/err got %b%b%b%b want %b%b%b%b", name,
                     cpu_reset, ld_if.ld_ready, ld_if.ld_done, ld_if.ld_err,
                     rst_w, rdy_w, done_w, err_w);
        end
    endtask

    task automatic check_mem(input string name, input int adr, input logic [7:0] want);
        cpu_adr = 4'(adr);
        #1;
        n_cmp++;
        if (cpu_data !== want) begin
            n_bad++;
            $display("FAIL %s: cpu_data[%0d] got %h want %h", name, adr, cpu_data, want);
        end
    endtask

    task automatic pulse_start(input string name);
        ld_if.ld_start = 1'b1;
        step();
        ld_if.ld_start = 1'b0;
        n_cmp++;
        if (ld_if.ld_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: ld_ready after start got %b want 1", name, ld_if.ld_ready);
        end
    endtask

    // Present one byte, after `gap` idle cycles, and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        for (int g = 0; g < gap; g++) begin
            ld_if.ld_valid = 1'b0;
            ld_if.ld_data  = 8'hC3;
            step();
        end
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (ld_if.ld_ready === 1'b1) ok = 1;
            step();
        end
        ld_if.ld_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte: byte %h not accepted within 50 cycles", b);
        end
    endtask

    function automatic logic [7:0] checksum_of_prog();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < TD4_DEPTH; i++) s = s + prog[i];
        return 8'h00 - s;
    endfunction

    task automatic send_prog(input logic [7:0] ck, input bit gaps);
        for (int i = 0; i < TD4_DEPTH; i++) send_byte(prog[i], gaps ? int'($urandom_range(0, 2)) : 0);
        send_byte(ck, gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic set_demo_prog();
        for (int i = 0; i < TD4_DEPTH; i++) prog[i] = 8'h00;
        prog[0] = 8'h3F; prog[1] = 8'h40; prog[2] = 8'h30; prog[3] = 8'h70;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_flags("reset_flags", 1, 0, 0, 0);
        for (int a = 0; a < TD4_DEPTH; a++) check_mem("reset_mem", a, 8'h00);
    endtask

    task automatic test_good_load();
        set_demo_prog();
        pulse_start("good_start");
        send_prog(8'hE1, 0);
        check_flags("good_release", 1, 0, 0, 0);
        // A start during the one-cycle RELEASE state is ignored.
        ld_if.ld_start = 1'b1;
        step();
        ld_if.ld_start = 1'b0;
        check_flags("good_run", 0, 0, 1, 0);
        step();
        check_flags("good_run_hold", 0, 0, 1, 0);
        check_mem("good_mem", 0, 8'h3F);
        check_mem("good_mem", 1, 8'h40);
        check_mem("good_mem", 2, 8'h30);
        check_mem("good_mem", 3, 8'h70);
        for (int a = 4; a < TD4_DEPTH; a++) check_mem("good_mem_zero", a, 8'h00);
    endtask

    task automatic test_bad_checksum();
        set_demo_prog();
        pulse_start("bad_start");
        send_prog(8'hE0, 0);
        check_flags("bad_err", 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step();
        check_flags("bad_err_hold", 1, 0, 0, 1);
        pulse_start("bad_restart");
        check_flags("bad_restart_flags", 1, 1, 0, 0);
        send_prog(8'hE1, 0);
        step();
        check_flags("bad_recover_run", 0, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        reset = 1'b1;
        step();
        reset = 1'b0;
        // Early bytes while not ready must be dropped.
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 8'hAA;
        for (int i = 0; i < 3; i++) step();
        check_flags("bp_early_flags", 1, 0, 0, 0);
        check_mem("bp_early_mem", 0, 8'h00);
        // Start with valid still high: the start cycle carries no beat.
        pulse_start("bp_start");
        ld_if.ld_valid = 1'b0;
        for (int i = 0; i < TD4_DEPTH; i++) prog[i] = 8'(i * 8'h11 + 8'h05);
        send_prog(checksum_of_prog(), 1);
        step();
        check_flags("bp_run", 0, 0, 1, 0);
        for (int a = 0; a < TD4_DEPTH; a++) check_mem("bp_mem", a, prog[a]);
    endtask

    task automatic test_restart();
        pulse_start("rs_start");
        for (int i = 0; i < 7; i++) send_byte(8'hFF, 0);
        // Restart with a beat in the same cycle: that byte must be discarded.
        ld_if.ld_start = 1'b1;
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 8'h55;
        step();
        ld_if.ld_start = 1'b0;
        ld_if.ld_valid = 1'b0;
        for (int i = 0; i < TD4_DEPTH; i++) prog[i] = 8'(8'h20 + i);
        send_prog(checksum_of_prog(), 0);
        step();
        check_flags("rs_run", 0, 0, 1, 0);
        for (int a = 0; a < TD4_DEPTH; a++) check_mem("rs_mem", a, prog[a]);
    endtask

    task automatic test_reload_and_reset();
        pulse_start("rl_start");
        check_flags("rl_flags", 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hA0 + 8'(i), 0);
            check_mem("rl_write_visible", i, 8'hA0 + 8'(i));
        end
        check_mem("rl_retained", 5, 8'h25);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_flags("rl_reset_flags", 1, 0, 0, 0);
        for (int a = 0; a < TD4_DEPTH; a++) check_mem("rl_reset_mem", a, 8'h00);
        pulse_start("rl_hold_start");
    endtask

    initial begin
        reset          = 1'b1;
        cpu_adr        = '0;
        ld_if.ld_start = 1'b0;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_data  = 8'h00;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_backpressure();
        test_restart();
        test_reload_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
Writable program store and boot sequencer for the td4 core; it replaces the fixed ROM behind rom_adr/rom_data. A host streams 16 instruction bytes plus 1 checksum byte over a valid/ready interface. The block holds the core in reset throughout the load and verifies the checksum. It releases the core only after a clean load.

Parameters:
ADR_W, 4, program address width; program depth = 2**ADR_W entries.
DATA_W, 8, instruction width.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
ld_start  input  1  single-cycle request to begin (or restart) a load.
ld_valid  input  1  host byte valid.
ld_data  input  DATA_W  host byte.
ld_ready  output  1  loader accepts a byte this cycle.
ld_done  output  1  level: last load passed checksum and core is running.
ld_err  output  1  level: last load failed checksum.
cpu_adr  input  ADR_W  instruction fetch address from core (rom_adr).
cpu_data  output  DATA_W  instruction to core (rom_data).
cpu_reset  output  1  reset to core, active-high.

Behaviour:
- Reset is synchronous and active-high on clk. On reset:
  - state=HOLD; all program entries=0x00.
  - cnt=0; sum=0.
  - cpu_reset=1, ld_ready=0, ld_done=0, ld_err=0.
- States: HOLD, LOAD, CHECK, RELEASE, RUN, ERROR. State is registered.
- Outputs are pure decodes of registered state:
  - ld_ready = (LOAD or CHECK).
  - cpu_reset = (state != RUN).
  - ld_done = RUN.
  - ld_err = ERROR.
- Beat = ld_valid & ld_ready. ld_valid while ld_ready=0 is ignored and nothing is stored.
- HOLD: ld_start -> LOAD next cycle, with cnt=0 and sum=0. Otherwise stay.
- LOAD, per beat:
  - mem[cnt] <= ld_data; sum <= sum + ld_data (mod 2**DATA_W); cnt <= cnt + 1.
  - The beat with cnt = 2**ADR_W - 1 moves to CHECK; cnt wraps to 0.
- CHECK, on a beat:
  - (sum + ld_data) mod 2**DATA_W == 0 -> RELEASE; otherwise -> ERROR.
  - The checksum byte is not stored.
- RELEASE: one cycle with cpu_reset still 1, so the core sees reset for at least one clk with the new program. Then unconditionally -> RUN.
- RUN: cpu_reset=0. ld_start -> LOAD, so cpu_reset=1 from the next cycle and ld_done drops.
- ERROR: stay until ld_start -> LOAD. Program contents are undefined-but-retained, and the core stays in reset.
- ld_start in LOAD or CHECK restarts the load: cnt=0, sum=0, state LOAD. Any same-cycle beat is discarded. Entries already written are retained until overwritten.
- ld_start has priority over a beat in every state.
- ld_start in RELEASE is ignored (one-cycle state).
- cpu_data = mem[cpu_adr], combinational/asynchronous read, matching the previous ROM timing.
  - Valid in every state.
  - A write to mem[k] is visible on cpu_data the cycle after the beat.
- Latency:
  - ld_start to ld_ready=1: 1 cycle.
  - Checksum beat to cpu_reset=0: 2 cycles (RELEASE, then RUN).
- Reset mid-load aborts the load: HOLD, memory cleared, all flags 0.

Decomposition:
- td4_pkg:
  - State enum td4_ld_state_t {HOLD, LOAD, CHECK, RELEASE, RUN, ERROR}.
  - Constants TD4_ADR_W=4, TD4_DATA_W=8, TD4_DEPTH=16.
- Sub-module td4_prog_ram: 2**ADR_W x DATA_W register file.
  - Synchronous write port (we, wadr, wdata).
  - Asynchronous read port.
  - Synchronous clear on reset.
- The FSM, counter and checksum accumulator live in td4_prog_loader.

Test Plan:
- Reset then idle 5 cycles -> cpu_reset=1, ld_ready=0, ld_done=0, ld_err=0, cpu_data=0x00 for all 16 cpu_adr values.
- Good load: ld_start, then bytes 3F 40 30 70 followed by 12x 00, then checksum E1.
  - Required: ld_ready=1 one cycle after ld_start.
  - After the E1 beat: RELEASE (cpu_reset=1) for 1 cycle, then cpu_reset=0 and ld_done=1.
  - cpu_adr=0..3 reads 3F,40,30,70.
  - With td4 attached and running, it executes MOV A,1111 / MOV B,A / MOV A,0000 / MOV B,0000.
- Bad checksum: same 16 bytes, checksum E0 -> ld_err=1, cpu_reset stays 1, ld_done=0.
  - A following ld_start plus a good load clears ld_err and reaches RUN.
- Backpressure and idle gaps: ld_valid toggled randomly, ld_valid asserted before ld_start -> only beats with ld_ready=1 are stored; early bytes are not stored.
- Restart: ld_start after 7 beats, then a full good load -> correct contents and checksum pass; the partial sum is discarded.
- Reload from RUN: ld_start -> cpu_reset=1 the next cycle, ld_done=0.
  - Assert reset mid-load -> all entries 0x00, state HOLD.
